// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction ROM: assembles little-endian words and holds the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_rst_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR, CHK} state_t;
    localparam state_t AFTER_LAST = CHK;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t      state, next;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic        accept;
    logic [15:0] len_full;
    logic        too_big;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept    = in_valid & in_ready;
    assign len_full  = {in_data, len[7:0]};
    assign too_big   = 32'(len_full) > (32'd1 << ADDR_WIDTH);
    // waddr doubles as the words-written counter: the last word sits at N-1
    assign last_word = 32'(waddr) == (32'(len) - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next         = state;
        in_ready     = 1'b0;
        we           = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        cpu_rst_hold = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (accept) next = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (too_big)            next = ERR;
                    else if (len_full == '0) next = AFTER_LAST;
                    else                    next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (accept && byte_idx == 2'd3) next = WRITE;
            end
            WRITE: begin
                we   = 1'b1;
                next = last_word ? AFTER_LAST : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (accept) next = (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                cpu_rst_hold = 1'b0;
                if (start) next = LEN_LO;
            end
            ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) next = LEN_LO;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len      <= '0;
            byte_idx <= '0;
            waddr    <= '0;
            wdata    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                LEN_LO: if (accept) len[7:0] <= in_data;
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        waddr     <= '0;
                        byte_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        wdata[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                    end
                end
                WRITE: if (!last_word) waddr <= waddr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, we, busy, done, err, cpu_rst_hold;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW+31:0] wlog[$];
    logic [31:0]    stim[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .cpu_rst_hold(cpu_rst_hold)
    );

    always @(negedge clk) if (we === 1'b1) wlog.push_back({waddr, wdata});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_of(input int gmode);
        return (gmode < 0) ? int'($urandom_range(0, 3)) : gmode;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) tick();
        if (in_ready !== 1'b1) check("ready_timeout", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_we"},       {63'd0, we}, 64'd0);
        check({tag, "_waddr"},    64'(waddr), 64'd0);
        check({tag, "_wdata"},    64'(wdata), 64'd0);
        check({tag, "_busy"},     {63'd0, busy}, 64'd0);
        check({tag, "_done"},     {63'd0, done}, 64'd0);
        check({tag, "_err"},      {63'd0, err}, 64'd0);
        check({tag, "_hold"},     {63'd0, cpu_rst_hold}, 64'd1);
    endtask

    // Model: a legal length yields exactly N writes of stim[0..N-1] at addresses 0..N-1.
    task automatic run_load(input int n, input int gmode, input bit bad_chk, input bit poke_start);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        logic [15:0] n16;
        bit          len_err, chk_fail, exp_err;
        int          exp_writes;
        x        = 8'h00;
        n16      = 16'(n);
        len_err  = n > (1 << AW);
        chk_fail = 1'b0;
        wlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_done", {63'd0, done}, 64'd0);
        check("start_err",  {63'd0, err}, 64'd0);
        check("start_hold", {63'd0, cpu_rst_hold}, 64'd1);
        send_byte(n16[7:0], gap_of(gmode));
        send_byte(n16[15:8], gap_of(gmode));
        if (!len_err) begin
            for (int wi = 0; wi < n; wi++) begin
                w = stim[wi];
                for (int k = 0; k < 4; k++) begin
                    b = w[8*k +: 8];
                    x = x ^ b;
                    send_byte(b, gap_of(gmode));
                    if (poke_start && wi == 0 && k == 1) begin
                        start = 1'b1;
                        tick();
                        start = 1'b0;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_fail = bad_chk;
            send_byte(bad_chk ? (x ^ 8'h01) : x, gap_of(gmode));
`endif
        end
        exp_err    = len_err || chk_fail;
        exp_writes = len_err ? 0 : n;
        for (int i = 0; i < 10 && done !== 1'b1 && err !== 1'b1; i++) tick();
        check("end_done", {63'd0, done}, {63'd0, !exp_err});
        check("end_err",  {63'd0, err}, {63'd0, exp_err});
        check("end_busy", {63'd0, busy}, 64'd0);
        check("end_hold", {63'd0, cpu_rst_hold}, {63'd0, exp_err});
        check("n_writes", 64'(wlog.size()), 64'(exp_writes));
        for (int i = 0; i < wlog.size() && i < exp_writes; i++) begin
            check("waddr", 64'(wlog[i][AW+31:32]), 64'(i));
            check("wdata", 64'(wlog[i][31:0]), 64'(stim[i]));
        end
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back($urandom);
    endtask

    initial begin
        #1;
        check_reset_outputs("por");
        tick();
        rst = 1'b1;
        tick();

        stim = {32'h00A00513, 32'h00100593};
        run_load(2, 0, 1'b0, 1'b0);

        stim = {32'hDEADBEEF};
        run_load(1, 3, 1'b0, 1'b0);

        run_load(0, 0, 1'b0, 1'b0);
        run_load(257, 0, 1'b0, 1'b0);

        fill_random(256);
        run_load(256, 0, 1'b0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            fill_random(int'($urandom_range(1, 12)));
            run_load(stim.size(), -1, 1'b0, r == 2);
        end

        // Asynchronous reset in the middle of a word
        fill_random(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        rst = 1'b1;
        tick();
        fill_random(3);
        run_load(3, -1, 1'b0, 1'b0);

        stim = {32'h44332211};
        run_load(1, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b1, 1'b0);
        fill_random(4);
        run_load(4, -1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction ROM interface. The CPU fetch path only reads this memory, addressed by PC.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at sequential word addresses.
- Holds the CPU (PC register) in reset until the load completes.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a byte this cycle.
we  output  1  memory write enable, one-cycle pulse per word.
waddr  output  ADDR_WIDTH  word address of the current write.
wdata  output  32  assembled instruction word.
busy  output  1  load in progress.
done  output  1  load completed successfully; sticky until next start.
err  output  1  load aborted; sticky until next start.
cpu_rst_hold  output  1  keeps the PC/CPU in reset while 1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_rst_hold=1, word/byte counters=0. Reset mid-load discards all progress; the memory contents already written are left as-is.
- Byte transfer occurs only on a cycle where in_valid=1 and in_ready=1.
- in_ready=1 only in states LEN_LO, LEN_HI and DATA (and CHK with the optional feature).
- Stream format: 16-bit word count N, sent little-endian (low byte first), followed by 4*N data bytes. Each word arrives LSB first.
- FSM:
  - IDLE: start goes to LEN_LO, sets busy=1 and cpu_rst_hold=1, clears done and err.
  - LEN_LO: accepted byte gives N[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte gives N[15:8]. If N > 2^ADDR_WIDTH, go to ERR. If N=0, go to DONE (or CHK). Otherwise go to DATA with waddr=0 and byte index=0.
  - DATA: accepted byte k (0..3) is placed in wdata[8k+7:8k]. After byte 3, go to WRITE.
  - WRITE: we=1 for exactly this cycle; waddr and wdata are stable. Next cycle: if words written == N, go to DONE (or CHK); else increment waddr and return to DATA.
  - DONE: busy=0, done=1, cpu_rst_hold=0. start restarts at LEN_LO.
  - ERR: busy=0, err=1, cpu_rst_hold=1. start restarts at LEN_LO.
- start is ignored while busy=1.
- Latency: the we pulse occurs the cycle after the 4th byte of a word is accepted. Minimum load time is 2 + 5N cycles after start (plus the start cycle).
- in_valid gaps may occur anywhere; the FSM waits without changing state.
- N = 2^ADDR_WIDTH is legal. The last write lands at waddr = 2^ADDR_WIDTH-1, and waddr does not wrap past it.
- Outside WRITE, wdata holds its last value and we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the final word (or after LEN_HI when N=0), state CHK accepts one extra byte.
  - The expected value is the XOR of all 4N data bytes (0x00 when N=0).
  - Match goes to DONE; mismatch goes to ERR with cpu_rst_hold=1.
  - Memory writes already performed are not undone.
- Undefined: no CHK state; the loader goes directly to DONE after the last WRITE.

Test Plan:
- Reset check: assert rst=0 mid-DATA -> all outputs return to reset values immediately; cpu_rst_hold=1; a following start reloads from LEN_LO.
- Basic load: start; stream 02 00 13 05 A0 00 93 05 10 00 -> we pulses with (waddr=0, wdata=0x00A00513) then (waddr=1, wdata=0x00100593); then done=1, busy=0, cpu_rst_hold=0.
- Flow control: stream 01 00 EF BE AD DE with in_valid low for 3 cycles between every byte -> a single we pulse with wdata=0xDEADBEEF at waddr=0; no extra or duplicate writes.
- Boundaries:
  - N=0 (00 00) -> DONE with no we pulse.
  - ADDR_WIDTH=8, N=0x0101 -> err=1 after the 2nd byte, no writes, cpu_rst_hold=1.
  - N=0x0100 -> 256 writes with last waddr=0xFF, then done=1.
- Start handling: start pulsed during DATA -> ignored, load continues. start in DONE -> done clears, busy=1, cpu_rst_hold=1.
- With IMEM_LOADER_CHECKSUM_EN:
  - 01 00 11 22 33 44 then 44 -> done=1.
  - Same stream with trailing 45 -> err=1, cpu_rst_hold=1.
